// File: rtl/spi_rx_multi_core.sv
// Multi-lane oversampling SPI receiver: per-lane deserialisers merged round-robin
// into one tagged 32-bit first-word-fall-through FIFO.

module spi_rx_lane #(
  parameter int         DATA_WIDTH = 16,
  parameter logic [3:0] IDENTIFIER = 4'b0001,
  parameter int         CH_IDX     = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        sclk,
  input  logic        sdi,
  input  logic        sen,
  input  logic        grant,
  output logic        vld,
  output logic [31:0] word,
  output logic        lost
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [1:0]            sclk_s, sdi_s, sen_s;
  logic                  sclk_d, rise, sdi_q, sen_q;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [7:0]            seq;

  assign shreg_nxt = DATA_WIDTH'({shreg, sdi_q});

  // rise/sdi_q/sen_q form a registered edge-detect stage so data and enable stay aligned
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s <= '0;
      sdi_s  <= '0;
      sen_s  <= '0;
      sclk_d <= 1'b0;
      rise   <= 1'b0;
      sdi_q  <= 1'b0;
      sen_q  <= 1'b0;
      cnt    <= '0;
      shreg  <= '0;
      seq    <= '0;
      vld    <= 1'b0;
      word   <= '0;
      lost   <= 1'b0;
    end else begin
      sclk_s <= {sclk_s[0], sclk};
      sdi_s  <= {sdi_s[0], sdi};
      sen_s  <= {sen_s[0], sen};
      sclk_d <= sclk_s[1];
      rise   <= sclk_s[1] & ~sclk_d;
      sdi_q  <= sdi_s[1];
      sen_q  <= sen_s[1];
      lost   <= 1'b0;
      if (grant) vld <= 1'b0;
      if (!en || !sen_q) begin
        cnt <= '0;
      end else if (rise) begin
        shreg <= shreg_nxt;
        if (cnt == CW'(DATA_WIDTH - 1)) begin
          cnt <= '0;
          seq <= seq + 8'd1;
          // a register being granted this cycle is free for the new word
          if (vld && !grant) begin
            lost <= 1'b1;
          end else begin
            vld  <= 1'b1;
            word <= {IDENTIFIER, 4'(CH_IDX), seq, 16'(shreg_nxt)};
          end
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

module spi_rx_multi_core #(
  parameter int         CHANNELS   = 4,
  parameter int         DATA_WIDTH = 16,
  parameter logic [3:0] IDENTIFIER = 4'b0001,
  parameter int         FIFO_DEPTH = 8
) (
  input  logic                BUS_CLK,
  input  logic                BUS_RST,
  input  logic                EN,
  input  logic [CHANNELS-1:0] SCLK,
  input  logic [CHANNELS-1:0] SDI,
  input  logic [CHANNELS-1:0] SEN,
  input  logic                FIFO_READ,
  output logic                FIFO_EMPTY,
  output logic [31:0]         FIFO_DATA,
  output logic [7:0]          LOST_COUNT
);
  localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CHANNELS-1:0]        vld, lost, grant;
  logic [CHANNELS-1:0][31:0]  word;
  logic [PW-1:0]              ptr, sel;
  logic                       any, push, pop, full;
  logic [AW:0]                wr_ptr, rd_ptr;
  logic [31:0]                mem [FIFO_DEPTH];
  logic [8:0]                 lost_sum;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    spi_rx_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .IDENTIFIER(IDENTIFIER),
      .CH_IDX    (i)
    ) u_lane (
      .clk  (BUS_CLK),
      .rst  (BUS_RST),
      .en   (EN),
      .sclk (SCLK[i]),
      .sdi  (SDI[i]),
      .sen  (SEN[i]),
      .grant(grant[i]),
      .vld  (vld[i]),
      .word (word[i]),
      .lost (lost[i])
    );
  end

  // ptr holds the highest-priority lane for the next grant
  always_comb begin
    any = 1'b0;
    sel = ptr;
    for (int i = 0; i < CHANNELS; i++) begin
      if (!any && vld[(int'(ptr) + i) % CHANNELS]) begin
        any = 1'b1;
        sel = PW'((int'(ptr) + i) % CHANNELS);
      end
    end
  end

  assign FIFO_EMPTY = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = FIFO_READ && !FIFO_EMPTY;
  assign push       = any && (!full || pop);
  assign FIFO_DATA  = FIFO_EMPTY ? 32'd0 : mem[rd_ptr[AW-1:0]];

  always_comb begin
    grant = '0;
    if (push) grant[sel] = 1'b1;
  end

  always_comb begin
    lost_sum = {1'b0, LOST_COUNT};
    for (int i = 0; i < CHANNELS; i++) lost_sum = lost_sum + 9'(lost[i]);
  end

  always_ff @(posedge BUS_CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= word[sel];
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      ptr        <= '0;
      LOST_COUNT <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        ptr    <= (sel == PW'(CHANNELS - 1)) ? '0 : sel + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      LOST_COUNT <= lost_sum[8] ? 8'hFF : lost_sum[7:0];
    end
  end
endmodule

// File: tb/tb_spi_rx_multi_core.sv
// Directed bench for spi_rx_multi_core: table of single-lane words plus
// hand-written multi-lane, overflow, partial-frame, reset and enable sequences.

module tb_spi_rx_multi_core;
  localparam int CH = 4;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST = 1'b0;
  logic          EN = 1'b1;
  logic [CH-1:0] SCLK = '0, SDI = '0, SEN = '0;
  logic          FIFO_READ = 1'b0;
  logic          FIFO_EMPTY;
  logic [31:0]   FIFO_DATA;
  logic [7:0]    LOST_COUNT;

  int checks = 0;
  int errors = 0;

  spi_rx_multi_core #(
    .CHANNELS  (CH),
    .DATA_WIDTH(16),
    .IDENTIFIER(4'b0001),
    .FIFO_DEPTH(2)
  ) dut (
    .BUS_CLK   (BUS_CLK),
    .BUS_RST   (BUS_RST),
    .EN        (EN),
    .SCLK      (SCLK),
    .SDI       (SDI),
    .SEN       (SEN),
    .FIFO_READ (FIFO_READ),
    .FIFO_EMPTY(FIFO_EMPTY),
    .FIFO_DATA (FIFO_DATA),
    .LOST_COUNT(LOST_COUNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  typedef struct {
    int          lane;
    logic [15:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[5];

  task automatic tick(input int n);
    repeat (n) @(negedge BUS_CLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge BUS_CLK);
    BUS_RST = 1'b1;
    SCLK = '0; SEN = '0; SDI = '0; FIFO_READ = 1'b0; EN = 1'b1;
    tick(2);
    BUS_RST = 1'b0;
    tick(2);
  endtask

  // MSB first, SCLK period = 4 BUS_CLK; returns right after the last rising edge
  task automatic spi_send(input logic [CH-1:0] lanes, input logic [CH-1:0][15:0] d, input int nbits);
    @(negedge BUS_CLK);
    SEN = SEN | lanes;
    tick(2);
    for (int b = 0; b < nbits; b++) begin
      SCLK = SCLK & ~lanes;
      for (int c = 0; c < CH; c++) if (lanes[c]) SDI[c] = d[c][15-b];
      tick(2);
      SCLK = SCLK | lanes;
      if (b != nbits - 1) tick(2);
    end
  endtask

  task automatic end_frame(input logic [CH-1:0] lanes);
    tick(4);
    SCLK = SCLK & ~lanes;
    SEN  = SEN & ~lanes;
    tick(4);
  endtask

  task automatic send1(input int lane, input logic [15:0] data);
    logic [CH-1:0]       m;
    logic [CH-1:0][15:0] d;
    m = '0; d = '0;
    m[lane] = 1'b1;
    d[lane] = data;
    spi_send(m, d, 16);
    end_frame(m);
  endtask

  task automatic pop_chk(input string name, input logic [31:0] exp);
    chk({name, "_notempty"}, {31'd0, FIFO_EMPTY}, 32'd0);
    chk(name, FIFO_DATA, exp);
    FIFO_READ = 1'b1;
    tick(1);
    FIFO_READ = 1'b0;
  endtask

  initial begin
    logic [CH-1:0]       m;
    logic [CH-1:0][15:0] d;

    tbl[0] = '{1, 16'h0001, 32'h1100_0001};
    tbl[1] = '{0, 16'hFFFF, 32'h1001_FFFF};
    tbl[2] = '{3, 16'h8000, 32'h1300_8000};
    tbl[3] = '{2, 16'h0000, 32'h1200_0000};
    tbl[4] = '{1, 16'h5A5A, 32'h1101_5A5A};

    do_reset();
    chk("rst_empty", {31'd0, FIFO_EMPTY}, 32'd1);
    chk("rst_data", FIFO_DATA, 32'd0);
    chk("rst_lost", {24'd0, LOST_COUNT}, 32'd0);

    // single word with exact latency from the last SCLK edge
    d = '0; d[0] = 16'hA5C3;
    spi_send(4'b0001, d, 16);
    repeat (4) @(posedge BUS_CLK);
    #1 chk("lat_empty_c4", {31'd0, FIFO_EMPTY}, 32'd1);
    @(posedge BUS_CLK);
    #1 chk("lat_empty_c5", {31'd0, FIFO_EMPTY}, 32'd0);
    end_frame(4'b0001);
    pop_chk("t1_word", 32'h1000_A5C3);
    chk("t1_empty", {31'd0, FIFO_EMPTY}, 32'd1);

    for (int i = 0; i < 5; i++) begin
      send1(tbl[i].lane, tbl[i].data);
      pop_chk($sformatf("vec%0d", i), tbl[i].exp);
      chk($sformatf("vec%0d_empty", i), {31'd0, FIFO_EMPTY}, 32'd1);
    end

    // simultaneous completion on all lanes
    do_reset();
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333; d[3] = 16'h4444;
    spi_send(4'b1111, d, 16);
    end_frame(4'b1111);
    pop_chk("t2_ch0", 32'h1000_1111);
    pop_chk("t2_ch1", 32'h1100_2222);
    pop_chk("t2_ch2", 32'h1200_3333);
    pop_chk("t2_ch3", 32'h1300_4444);
    chk("t2_empty", {31'd0, FIFO_EMPTY}, 32'd1);

    // overflow: FIFO (2) + holding register full, fourth word lost
    do_reset();
    d = '0; m = 4'b0100;
    d[2] = 16'h0A01; spi_send(m, d, 16);
    d[2] = 16'h0A02; spi_send(m, d, 16);
    d[2] = 16'h0A03; spi_send(m, d, 16);
    end_frame(m);
    chk("t3_head", FIFO_DATA, 32'h1200_0A01);
    chk("t3_lost0", {24'd0, LOST_COUNT}, 32'd0);
    d[2] = 16'h0A04; spi_send(m, d, 16);
    end_frame(m);
    chk("t3_lost1", {24'd0, LOST_COUNT}, 32'd1);
    pop_chk("t3_seq0", 32'h1200_0A01);
    pop_chk("t3_seq1", 32'h1201_0A02);
    pop_chk("t3_seq2", 32'h1202_0A03);
    chk("t3_empty", {31'd0, FIFO_EMPTY}, 32'd1);
    chk("t3_lost_hold", {24'd0, LOST_COUNT}, 32'd1);

    // partial frame discarded
    do_reset();
    d = '0; d[1] = 16'hFFFF;
    spi_send(4'b0010, d, 9);
    end_frame(4'b0010);
    send1(1, 16'hBEEF);
    pop_chk("t4_word", 32'h1100_BEEF);
    chk("t4_empty", {31'd0, FIFO_EMPTY}, 32'd1);
    chk("t4_lost", {24'd0, LOST_COUNT}, 32'd0);

    // reset mid-frame with two words queued
    do_reset();
    send1(0, 16'h0001);
    send1(0, 16'h0002);
    chk("t5_queued", FIFO_DATA, 32'h1000_0001);
    d = '0; d[0] = 16'h0F0F;
    spi_send(4'b0001, d, 8);
    BUS_RST = 1'b1;
    tick(1);
    BUS_RST = 1'b0;
    chk("t5_empty", {31'd0, FIFO_EMPTY}, 32'd1);
    chk("t5_data", FIFO_DATA, 32'd0);
    chk("t5_lost", {24'd0, LOST_COUNT}, 32'd0);
    end_frame(4'b0001);
    send1(0, 16'h1234);
    pop_chk("t5_seq0", 32'h1000_1234);

    // EN dropped mid-frame, then read on empty FIFO
    do_reset();
    d = '0; d[3] = 16'hAAAA;
    spi_send(4'b1000, d, 8);
    EN = 1'b0;
    spi_send(4'b1000, d, 8);
    end_frame(4'b1000);
    EN = 1'b1;
    tick(8);
    chk("t6_no_word", {31'd0, FIFO_EMPTY}, 32'd1);
    FIFO_READ = 1'b1;
    tick(1);
    FIFO_READ = 1'b0;
    chk("t6_rd_empty", {31'd0, FIFO_EMPTY}, 32'd1);
    chk("t6_rd_data", FIFO_DATA, 32'd0);
    send1(3, 16'hC0DE);
    pop_chk("t6_word", 32'h1300_C0DE);
    chk("t6_empty", {31'd0, FIFO_EMPTY}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
